// File: rtl/regfile_wb_queue_if.sv
// Writeback request, register-file write port and forwarding read ports of the writeback queue.
// The slave modport is the queue side. The master modport is the pipeline/register-file side.
interface regfile_wb_queue_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_sel;
  logic [31:0] wb_dat;
  logic        drain_en;
  logic        rf_WEN;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  logic [4:0]  rsel1;
  logic [4:0]  rsel2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_dat;
  logic [31:0] fwd2_dat;

  modport slave (
    input  wb_valid, wb_sel, wb_dat, drain_en, rsel1, rsel2,
    output wb_ready, rf_WEN, rf_wsel, rf_wdat, fwd1_hit, fwd2_hit, fwd1_dat, fwd2_dat
  );

  modport master (
    output wb_valid, wb_sel, wb_dat, drain_en, rsel1, rsel2,
    input  wb_ready, rf_WEN, rf_wsel, rf_wdat, fwd1_hit, fwd2_hit, fwd1_dat, fwd2_dat
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue in front of the register file write port, with read-port forwarding.
// DEPTH must be a power of two, at least 2, so that the pointers wrap naturally.
module regfile_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  regfile_wb_queue_if.slave        bus,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    sel_q [DEPTH];
  logic [31:0]   dat_q [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          not_empty;
  logic          push;
  logic          pop;

  assign not_empty    = (cnt != '0);
  assign bus.wb_ready = (cnt != CW'(DEPTH));
  // Writes to r0 are acknowledged but never queued.
  assign push         = bus.wb_valid && bus.wb_ready && (bus.wb_sel != 5'd0);
  assign pop          = bus.drain_en && not_empty;

  assign bus.rf_WEN  = pop;
  assign bus.rf_wsel = not_empty ? sel_q[head] : 5'd0;
  assign bus.rf_wdat = not_empty ? dat_q[head] : 32'd0;
  assign count       = cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  // Entry storage is not reset; validity comes from head and cnt only.
  always_ff @(posedge CLK) begin
    if (push) begin
      sel_q[tail] <= bus.wb_sel;
      dat_q[tail] <= bus.wb_dat;
    end
  end

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    bus.fwd1_hit = 1'b0;
    bus.fwd1_dat = 32'd0;
    bus.fwd2_hit = 1'b0;
    bus.fwd2_dat = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt) begin
        if ((bus.rsel1 != 5'd0) && (sel_q[head + AW'(i)] == bus.rsel1)) begin
          bus.fwd1_hit = 1'b1;
          bus.fwd1_dat = dat_q[head + AW'(i)];
        end
        if ((bus.rsel2 != 5'd0) && (sel_q[head + AW'(i)] == bus.rsel2)) begin
          bus.fwd2_hit = 1'b1;
          bus.fwd2_dat = dat_q[head + AW'(i)];
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue (DEPTH = 4).
module tb_regfile_wb_queue;
  logic       CLK;
  logic       nRST;
  logic [2:0] count;
  int         checks;
  int         errors;

  regfile_wb_queue_if bus ();

  regfile_wb_queue #(.DEPTH(4)) dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .bus   (bus),
    .count (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_wait(input logic [4:0] s, input logic [31:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_sel   = s;
    bus.wb_dat   = d;
    tick();
    bus.wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_sel = '0; bus.wb_dat = '0;
    bus.drain_en = 1'b0; bus.rsel1 = '0; bus.rsel2 = '0;
    #12 nRST = 1'b1;
    tick();
    #1;
    checks++; if (bus.wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", bus.wb_ready); end
    checks++; if (bus.rf_WEN !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b exp 0", bus.rf_WEN); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
    checks++; if (bus.rf_wsel !== 5'd0 || bus.rf_wdat !== 32'd0) begin errors++; $display("FAIL reset_rf: got %h/%h exp 0/0", bus.rf_wsel, bus.rf_wdat); end
    checks++; if (bus.fwd1_hit !== 1'b0 || bus.fwd2_hit !== 1'b0 || bus.fwd1_dat !== 32'd0) begin errors++; $display("FAIL reset_fwd: got %b%b %h exp 00 0", bus.fwd1_hit, bus.fwd2_hit, bus.fwd1_dat); end
  endtask

  task automatic test_single();
    bus.rsel1 = 5'd5;
    bus.wb_valid = 1'b1; bus.wb_sel = 5'd5; bus.wb_dat = 32'hDEADBEEF;
    #1;
    checks++; if (bus.fwd1_hit !== 1'b0) begin errors++; $display("FAIL single_nofwd_same_cycle: got %b exp 0", bus.fwd1_hit); end
    tick();
    bus.wb_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d exp 1", count); end
    checks++; if (bus.fwd1_hit !== 1'b1 || bus.fwd1_dat !== 32'hDEADBEEF) begin errors++; $display("FAIL single_fwd: got %b %h exp 1 deadbeef", bus.fwd1_hit, bus.fwd1_dat); end
    checks++; if (bus.rf_WEN !== 1'b0 || bus.rf_wsel !== 5'd5) begin errors++; $display("FAIL single_held: got %b %0d exp 0 5", bus.rf_WEN, bus.rf_wsel); end
    bus.drain_en = 1'b1;
    #1;
    checks++; if (bus.rf_WEN !== 1'b1 || bus.rf_wsel !== 5'd5 || bus.rf_wdat !== 32'hDEADBEEF) begin errors++; $display("FAIL single_drain: got %b %0d %h exp 1 5 deadbeef", bus.rf_WEN, bus.rf_wsel, bus.rf_wdat); end
    checks++; if (bus.fwd1_hit !== 1'b1) begin errors++; $display("FAIL single_fwd_while_drain: got %b exp 1", bus.fwd1_hit); end
    tick();
    bus.drain_en = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || bus.fwd1_hit !== 1'b0 || bus.rf_WEN !== 1'b0) begin errors++; $display("FAIL single_empty: got %0d %b %b exp 0 0 0", count, bus.fwd1_hit, bus.rf_WEN); end
  endtask

  task automatic test_full_wrap();
    logic [4:0] exp_sel [4];
    logic [31:0] exp_dat [4];
    for (int i = 1; i <= 4; i++) push_wait(5'(i), 32'h100 + 32'(i));
    #1;
    checks++; if (count !== 3'd4 || bus.wb_ready !== 1'b0) begin errors++; $display("FAIL full_state: got %0d %b exp 4 0", count, bus.wb_ready); end
    bus.rsel1 = 5'd9;
    bus.wb_valid = 1'b1; bus.wb_sel = 5'd9; bus.wb_dat = 32'h99;
    tick();
    checks++; if (count !== 3'd4 || bus.fwd1_hit !== 1'b0) begin errors++; $display("FAIL full_held: got %0d %b exp 4 0", count, bus.fwd1_hit); end
    bus.drain_en = 1'b1;
    #1;
    checks++; if (bus.rf_WEN !== 1'b1 || bus.rf_wsel !== 5'd1 || bus.rf_wdat !== 32'h101 || bus.wb_ready !== 1'b0) begin errors++; $display("FAIL full_drain_r1: got %b %0d %h %b exp 1 1 101 0", bus.rf_WEN, bus.rf_wsel, bus.rf_wdat, bus.wb_ready); end
    tick();
    bus.drain_en = 1'b0;
    #1;
    checks++; if (count !== 3'd3 || bus.wb_ready !== 1'b1) begin errors++; $display("FAIL full_reopen: got %0d %b exp 3 1", count, bus.wb_ready); end
    tick();
    bus.wb_valid = 1'b0;
    bus.rsel2 = 5'd9;
    #1;
    checks++; if (count !== 3'd4 || bus.fwd2_hit !== 1'b1 || bus.fwd2_dat !== 32'h99) begin errors++; $display("FAIL full_late_enq: got %0d %b %h exp 4 1 99", count, bus.fwd2_hit, bus.fwd2_dat); end
    exp_sel = '{5'd2, 5'd3, 5'd4, 5'd9};
    exp_dat = '{32'h102, 32'h103, 32'h104, 32'h99};
    bus.drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.rf_WEN !== 1'b1 || bus.rf_wsel !== exp_sel[i] || bus.rf_wdat !== exp_dat[i]) begin errors++; $display("FAIL wrap_order[%0d]: got %b %0d %h exp 1 %0d %h", i, bus.rf_WEN, bus.rf_wsel, bus.rf_wdat, exp_sel[i], exp_dat[i]); end
      tick();
    end
    bus.drain_en = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || bus.fwd2_hit !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %0d %b exp 0 0", count, bus.fwd2_hit); end
    bus.rsel1 = '0; bus.rsel2 = '0;
  endtask

  task automatic test_same_reg();
    logic [31:0] exp_dat [2];
    push_wait(5'd7, 32'h1);
    push_wait(5'd7, 32'h2);
    bus.rsel2 = 5'd7;
    #1;
    checks++; if (count !== 3'd2 || bus.fwd2_hit !== 1'b1 || bus.fwd2_dat !== 32'h2) begin errors++; $display("FAIL same_youngest: got %0d %b %h exp 2 1 2", count, bus.fwd2_hit, bus.fwd2_dat); end
    exp_dat = '{32'h1, 32'h2};
    bus.drain_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.rf_wsel !== 5'd7 || bus.rf_wdat !== exp_dat[i] || bus.fwd2_dat !== 32'h2) begin errors++; $display("FAIL same_order[%0d]: got %0d %h fwd %h exp 7 %h fwd 2", i, bus.rf_wsel, bus.rf_wdat, bus.fwd2_dat, exp_dat[i]); end
      tick();
    end
    bus.drain_en = 1'b0;
    #1;
    checks++; if (bus.fwd2_hit !== 1'b0 || bus.fwd2_dat !== 32'd0) begin errors++; $display("FAIL same_gone: got %b %h exp 0 0", bus.fwd2_hit, bus.fwd2_dat); end
    bus.rsel2 = '0;
  endtask

  task automatic test_back_to_back();
    bus.drain_en = 1'b1;
    bus.wb_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wb_sel = 5'd10 + 5'(i);
      bus.wb_dat = 32'hA0 + 32'(i);
      tick();
      #1;
      checks++; if (count !== 3'd1 || bus.rf_WEN !== 1'b1 || bus.rf_wsel !== 5'd10 + 5'(i) || bus.rf_wdat !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL b2b[%0d]: got %0d %b %0d %h exp 1 1 %0d %h", i, count, bus.rf_WEN, bus.rf_wsel, bus.rf_wdat, 10 + i, 32'hA0 + 32'(i)); end
    end
    bus.wb_valid = 1'b0;
    tick();
    checks++; if (count !== 3'd0 || bus.rf_WEN !== 1'b0) begin errors++; $display("FAIL b2b_end: got %0d %b exp 0 0", count, bus.rf_WEN); end
    bus.drain_en = 1'b0;
  endtask

  task automatic test_r0();
    bus.drain_en = 1'b1;
    bus.rsel1 = 5'd0;
    bus.wb_valid = 1'b1; bus.wb_sel = 5'd0; bus.wb_dat = 32'hFFFFFFFF;
    #1;
    checks++; if (bus.wb_ready !== 1'b1) begin errors++; $display("FAIL r0_ready: got %b exp 1", bus.wb_ready); end
    tick();
    bus.wb_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (count !== 3'd0 || bus.rf_WEN !== 1'b0 || bus.fwd1_hit !== 1'b0) begin errors++; $display("FAIL r0_dropped[%0d]: got %0d %b %b exp 0 0 0", i, count, bus.rf_WEN, bus.fwd1_hit); end
      tick();
    end
    bus.drain_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) push_wait(5'd20 + 5'(i), 32'hC0 + 32'(i));
    bus.rsel1 = 5'd21;
    #1;
    checks++; if (count !== 3'd3 || bus.fwd1_hit !== 1'b1 || bus.fwd1_dat !== 32'hC1) begin errors++; $display("FAIL mid_pre: got %0d %b %h exp 3 1 c1", count, bus.fwd1_hit, bus.fwd1_dat); end
    #1 nRST = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || bus.fwd1_hit !== 1'b0 || bus.rf_wsel !== 5'd0 || bus.wb_ready !== 1'b1) begin errors++; $display("FAIL mid_async: got %0d %b %0d %b exp 0 0 0 1", count, bus.fwd1_hit, bus.rf_wsel, bus.wb_ready); end
    #3 nRST = 1'b1;
    bus.drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.rf_WEN !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL mid_no_wen[%0d]: got %b %0d exp 0 0", i, bus.rf_WEN, count); end
    end
    bus.drain_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_full_wrap();
    test_same_reg();
    test_back_to_back();
    test_r0();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
